// File: rtl/wb_csr_pkg.sv
// Shared constants, hit types and helpers for the Wishbone CSR bank.
package wb_csr_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    HIT_RW   = 2'd0,
    HIT_RO   = 2'd1,
    HIT_STAT = 2'd2,
    HIT_EN   = 2'd3
  } hit_e;

  function automatic int evt_stat_idx(input int num_rw, input int num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic int evt_en_idx(input int num_rw, input int num_ro);
    return num_rw + num_ro + 1;
  endfunction

  function automatic logic [WORD_W-1:0] byte_mask(input logic [3:0] sel);
    logic [WORD_W-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_csr_decode.sv
// Combinational address decoder: byte address -> word index, hit type, error.
module wb_csr_decode
  import wb_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_RW    = 4,
  parameter int          NUM_RO    = 2
) (
  input  logic [31:0]      adr_i,
  output logic [IDX_W-1:0] idx_o,
  output hit_e             hit_o,
  output logic             err_o
);

  localparam logic [29:0] W_RO   = 30'(NUM_RW);
  localparam logic [29:0] W_STAT = 30'(evt_stat_idx(NUM_RW, NUM_RO));
  localparam logic [29:0] W_EN   = 30'(evt_en_idx(NUM_RW, NUM_RO));

  logic [29:0] word;

  always_comb begin
    // BASE_ADDR is word aligned, so the index is a plain word-address difference
    word  = adr_i[31:2] - BASE_ADDR[31:2];
    idx_o = '0;
    hit_o = HIT_RW;
    err_o = 1'b0;
    if (adr_i[1:0] != 2'b00 || adr_i < BASE_ADDR || word > W_EN) begin
      err_o = 1'b1;
    end else begin
      idx_o = word[IDX_W-1:0];
      if (word < W_RO)        hit_o = HIT_RW;
      else if (word < W_STAT) hit_o = HIT_RO;
      else if (word == W_STAT) hit_o = HIT_STAT;
      else                    hit_o = HIT_EN;
    end
  end

endmodule

// File: rtl/wb_csr_bank.sv
// Wishbone B4 classic CSR bank: byte-lane RW registers, sampled RO status,
// sticky W1C event register with enable mask and a flop-driven interrupt.
module wb_csr_bank
  import wb_csr_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR = 32'h3000_0000,
  parameter int                   NUM_RW    = 4,
  parameter int                   NUM_RO    = 2,
  parameter logic [32*NUM_RW-1:0] RW_RESET  = '0,
  parameter int                   NUM_EVT   = 8
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_ni,
  input  logic                                   wbs_stb_i,
  input  logic                                   wbs_cyc_i,
  input  logic                                   wbs_we_i,
  input  logic [3:0]                             wbs_sel_i,
  input  logic [31:0]                            wbs_dat_i,
  input  logic [31:0]                            wbs_adr_i,
  output logic                                   wbs_ack_o,
  output logic                                   wbs_err_o,
  output logic [31:0]                            wbs_dat_o,
  output logic [32*NUM_RW-1:0]                   rw_regs_o,
  output logic [NUM_RW-1:0]                      wr_pulse_o,
  input  logic [32*((NUM_RO > 0) ? NUM_RO : 1)-1:0] ro_regs_i,
  input  logic [NUM_EVT-1:0]                     evt_i,
  output logic                                   irq_o
);

  logic             ack_q, ack_d, err_q, err_d;
  logic [31:0]      dat_q, dat_d;
  logic [NUM_RW-1:0] pulse_q, pulse_d;
  logic [NUM_RW-1:0][31:0] rw_q, rw_d;
  logic [NUM_EVT-1:0] stat_q, stat_d, en_q, en_d;

  logic [IDX_W-1:0] dec_idx;
  hit_e             dec_hit;
  logic             dec_err;

  logic             accept, bad;
  logic [31:0]      mask, rd;
  logic [NUM_EVT-1:0] evt_mask, clr;

  wb_csr_decode #(
    .BASE_ADDR(BASE_ADDR),
    .NUM_RW   (NUM_RW),
    .NUM_RO   (NUM_RO)
  ) u_decode (
    .adr_i(wbs_adr_i),
    .idx_o(dec_idx),
    .hit_o(dec_hit),
    .err_o(dec_err)
  );

  always_comb begin
    accept   = wbs_stb_i & wbs_cyc_i & ~ack_q & ~err_q;
    bad      = dec_err | (wbs_we_i & (dec_hit == HIT_RO));
    mask     = byte_mask(wbs_sel_i);
    evt_mask = mask[NUM_EVT-1:0];
    ack_d    = accept & ~bad;
    err_d    = accept & bad;
    dat_d    = dat_q;
    rw_d     = rw_q;
    en_d     = en_q;
    pulse_d  = '0;
    clr      = '0;
    rd       = '0;

    case (dec_hit)
      HIT_RW:   for (int i = 0; i < NUM_RW; i++)
                  if (dec_idx == IDX_W'(i)) rd = rw_q[i];
      HIT_RO:   for (int i = 0; i < NUM_RO; i++)
                  if (dec_idx == IDX_W'(NUM_RW + i)) rd = ro_regs_i[32*i +: 32];
      HIT_STAT: rd[NUM_EVT-1:0] = stat_q;
      default:  rd[NUM_EVT-1:0] = en_q;
    endcase

    if (err_d)                 dat_d = '0;
    else if (ack_d && !wbs_we_i) dat_d = rd;

    if (ack_d && wbs_we_i) begin
      case (dec_hit)
        HIT_RW:   for (int i = 0; i < NUM_RW; i++)
                    if (dec_idx == IDX_W'(i)) begin
                      rw_d[i]    = (rw_q[i] & ~mask) | (wbs_dat_i & mask);
                      pulse_d[i] = |wbs_sel_i;
                    end
        HIT_STAT: clr  = wbs_dat_i[NUM_EVT-1:0] & evt_mask;
        HIT_EN:   en_d = (en_q & ~evt_mask) | (wbs_dat_i[NUM_EVT-1:0] & evt_mask);
        default:  ;
      endcase
    end

    // A new event on the same edge as its W1C keeps the bit set
    stat_d = (stat_q & ~clr) | evt_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      pulse_q <= '0;
      rw_q    <= RW_RESET;
      stat_q  <= '0;
      en_q    <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      pulse_q <= pulse_d;
      rw_q    <= rw_d;
      stat_q  <= stat_d;
      en_q    <= en_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = err_q;
  assign wbs_dat_o  = dat_q;
  assign wr_pulse_o = pulse_q;
  assign rw_regs_o  = rw_q;
  assign irq_o      = |(stat_q & en_q);

endmodule

// File: tb/tb_wb_csr_bank.sv
// Directed self-checking bench for wb_csr_bank (NUM_RW=4, NUM_RO=2, NUM_EVT=8).
module tb_wb_csr_bank;

  localparam logic [127:0] RST_VAL = {32'h0, 32'h0, 32'h0000_00fb, 32'h0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  wdat = '0, adr = '0;
  logic         ack, err, irq;
  logic [31:0]  rdat;
  logic [127:0] rw_regs;
  logic [3:0]   pulse;
  logic [63:0]  ro_regs = {32'h2222_2222, 32'h1111_1111};
  logic [7:0]   evt = 8'h00;

  int checks = 0;
  int failures = 0;

  logic        r_ack, r_err, r_ack2, r_err2;
  logic [31:0] r_dat, r_dat2;
  logic [3:0]  r_pulse, r_pulse2;

  wb_csr_bank #(
    .BASE_ADDR(32'h3000_0000),
    .NUM_RW   (4),
    .NUM_RO   (2),
    .RW_RESET (RST_VAL),
    .NUM_EVT  (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_err_o (err),
    .wbs_dat_o (rdat),
    .rw_regs_o (rw_regs),
    .wr_pulse_o(pulse),
    .ro_regs_i (ro_regs),
    .evt_i     (evt),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transaction; captures the termination cycle and the cycle after it.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    r_ack = ack; r_err = err; r_dat = rdat; r_pulse = pulse;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    r_ack2 = ack; r_err2 = err; r_dat2 = rdat; r_pulse2 = pulse;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 128'(ack), 128'(1'b0));
    chk("rst_err", 128'(err), 128'(1'b0));
    chk("rst_dat", 128'(rdat), 128'h0);
    chk("rst_pulse", 128'(pulse), 128'h0);
    chk("rst_regs", rw_regs, RST_VAL);
    chk("rst_irq", 128'(irq), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Read reset value of word 1
    access(1'b0, 32'h3000_0004, 4'hF, 32'h0);
    chk("rd1_ack", 128'(r_ack), 128'(1'b1));
    chk("rd1_err", 128'(r_err), 128'(1'b0));
    chk("rd1_dat", 128'(r_dat), 128'h0000_00fb);
    chk("rd1_ack_once", 128'(r_ack2), 128'(1'b0));
    chk("rd1_dat_hold", 128'(r_dat2), 128'h0000_00fb);
    chk("rd1_irq", 128'(irq), 128'(1'b0));

    // Byte-lane write to reg0
    access(1'b1, 32'h3000_0000, 4'b0101, 32'hAABB_CCDD);
    chk("wr0_ack", 128'(r_ack), 128'(1'b1));
    chk("wr0_pulse", 128'(r_pulse), 128'h1);
    chk("wr0_pulse_once", 128'(r_pulse2), 128'h0);
    chk("wr0_reg", 128'(rw_regs[31:0]), 128'h00BB_00DD);
    chk("wr0_hold_dat", 128'(r_dat), 128'h0000_00fb);
    access(1'b0, 32'h3000_0000, 4'h0, 32'h0);
    chk("rb0_dat", 128'(r_dat), 128'h00BB_00DD);

    // RO reads, sampled at accept
    access(1'b0, 32'h3000_0014, 4'hF, 32'h0);
    chk("ro1_dat", 128'(r_dat), 128'h2222_2222);
    ro_regs[31:0] = 32'h5A5A_0001;
    access(1'b0, 32'h3000_0010, 4'hF, 32'h0);
    chk("ro0_dat", 128'(r_dat), 128'h5A5A_0001);

    // Error terminations
    access(1'b1, 32'h3000_0010, 4'hF, 32'hFFFF_FFFF);
    chk("wro_err", 128'(r_err), 128'(1'b1));
    chk("wro_ack", 128'(r_ack), 128'(1'b0));
    chk("wro_err_once", 128'(r_err2), 128'(1'b0));
    chk("wro_dat", 128'(r_dat), 128'h0);
    access(1'b0, 32'h3000_0002, 4'hF, 32'h0);
    chk("mis_err", 128'(r_err), 128'(1'b1));
    chk("mis_ack", 128'(r_ack), 128'(1'b0));
    access(1'b0, 32'h3000_0020, 4'hF, 32'h0);
    chk("beyond_err", 128'(r_err), 128'(1'b1));
    access(1'b1, 32'h2FFF_FFFC, 4'hF, 32'h1234_5678);
    chk("below_err", 128'(r_err), 128'(1'b1));
    chk("err_regs", rw_regs, {32'h0, 32'h0, 32'h0000_00fb, 32'h00BB_00DD});

    // sel=0 write: acked, no change, no pulse
    access(1'b1, 32'h3000_0008, 4'h0, 32'hFFFF_FFFF);
    chk("sel0_ack", 128'(r_ack), 128'(1'b1));
    chk("sel0_pulse", 128'(r_pulse), 128'h0);
    chk("sel0_reg", 128'(rw_regs[95:64]), 128'h0);

    // Sticky event, enable, W1C
    @(negedge clk); evt = 8'h08;
    @(negedge clk); evt = 8'h00;
    access(1'b0, 32'h3000_0018, 4'hF, 32'h0);
    chk("stat_set", 128'(r_dat), 128'h8);
    chk("irq_masked", 128'(irq), 128'(1'b0));
    access(1'b1, 32'h3000_001C, 4'hF, 32'h0000_0008);
    chk("en_irq", 128'(r_ack ? irq : 1'bx), 128'(1'b1));
    access(1'b0, 32'h3000_001C, 4'hF, 32'h0);
    chk("en_rd", 128'(r_dat), 128'h8);
    access(1'b1, 32'h3000_0018, 4'hF, 32'h0000_0008);
    chk("w1c_irq", 128'(irq), 128'(1'b0));
    access(1'b0, 32'h3000_0018, 4'hF, 32'h0);
    chk("w1c_stat", 128'(r_dat), 128'h0);

    // Set wins over simultaneous clear
    @(negedge clk); evt = 8'h08;
    access(1'b1, 32'h3000_0018, 4'hF, 32'h0000_0008);
    access(1'b0, 32'h3000_0018, 4'hF, 32'h0);
    chk("setwins_stat", 128'(r_dat), 128'h8);
    chk("setwins_irq", 128'(irq), 128'(1'b1));
    @(negedge clk); evt = 8'h00;
    access(1'b1, 32'h3000_0018, 4'hF, 32'h0000_0008);
    chk("clr_irq", 128'(irq), 128'(1'b0));

    // Reset right after accepting a write
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_000C; sel = 4'hF; wdat = 32'h1234_5678;
    @(posedge clk); #1;
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    #1;
    chk("mrst_ack", 128'(ack), 128'(1'b0));
    chk("mrst_pulse", 128'(pulse), 128'h0);
    chk("mrst_regs", rw_regs, RST_VAL);
    chk("mrst_irq", 128'(irq), 128'(1'b0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ack", 128'(ack), 128'(1'b0));
    chk("idle_err", 128'(err), 128'(1'b0));
    access(1'b0, 32'h3000_000C, 4'hF, 32'h0);
    chk("post_rd3", 128'(r_dat), 128'h0);
    chk("post_ack", 128'(r_ack), 128'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_csr_bank.md
Name: wb_csr_bank

Overview:
- Parametrised Wishbone B4 classic slave CSR bank; next generation of the fixed MAC/IP/port register block.
- Provides NUM_RW read/write registers with byte-lane writes and NUM_RO read-only status registers.
- Adds a sticky event/interrupt pair (write-1-to-clear status register plus enable register), and error termination for bad accesses.
- Sits between the Caravel-side Wishbone bus and the Ethernet datapath, which consumes rw_regs_o and supplies ro_regs_i and evt_i.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of word 0.
- NUM_RW, 4, number of 32-bit RW registers (1..16).
- NUM_RO, 2, number of 32-bit RO registers (0..16).
- RW_RESET, {NUM_RW{32'h0}}, packed reset values; register i occupies bits [32*i+31:32*i].
- NUM_EVT, 8, number of event bits (1..32).

Ports:
- wb_clk_i  in  1  bus and fabric clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  normal termination.
- wbs_err_o  out  1  error termination.
- wbs_dat_o  out  32  read data.
- rw_regs_o  out  32*NUM_RW  RW register contents.
- wr_pulse_o  out  NUM_RW  one-cycle pulse per RW register updated.
- ro_regs_i  in  32*max(NUM_RO,1)  status inputs, sampled at read.
- evt_i  in  NUM_EVT  level event sources.
- irq_o  out  1  interrupt request.

Behaviour:
- Reset (async assert, sync release): ack=0, err=0, dat_o=0, wr_pulse_o=0, rw_regs_o=RW_RESET, EVT_STATUS=0, EVT_ENABLE=0.
- Word map, index = (adr-BASE_ADDR)>>2:
  - 0..NUM_RW-1: RW registers.
  - next NUM_RO words: RO registers.
  - next word: EVT_STATUS (read, W1C).
  - next word: EVT_ENABLE (RW).
  - Unused upper bits of the event words read 0.
- Accept: a request is taken on an edge where stb&cyc&!ack_o&!err_o.
- Exactly one of ack_o/err_o is high on the next cycle, for one cycle only. Latency is 1 cycle; throughput is one access per 2 cycles.
- err_o is raised, with no state change and dat_o=0, for any of:
  - adr[1:0]!=0;
  - index beyond the map;
  - adr below BASE_ADDR;
  - a write to an RO register.
- Write, RW or EVT_ENABLE: only bytes with sel set update, on the same edge ack rises. wr_pulse_o[i] is high during the ack cycle if sel!=0. A write with sel=0 is acked, changes nothing and gives no pulse.
- Write, EVT_STATUS: bits where data&sel-lane mask is 1 are cleared.
- Read: dat_o is registered and valid during the ack cycle. RO values are sampled on the accepting edge. sel is ignored on reads. dat_o holds its last value otherwise.
- Events: on every edge, EVT_STATUS |= evt_i. If a set and a W1C of the same bit coincide, the set wins (status stays 1).
- irq_o = |(EVT_STATUS & EVT_ENABLE), driven from flops only; there is no combinational path from the bus.
- cyc dropped while ack/err is pending: termination still pulses one cycle and the write still commits; the master ignores it.
- Reset mid-access: the pending ack/err is dropped, and registers return to reset values asynchronously.

Decomposition:
- Package wb_csr_pkg holds: the word-width constant 32; the helper function computing EVT_STATUS/EVT_ENABLE indices from NUM_RW/NUM_RO; the byte-mask expansion function (sel -> 32-bit mask).
- One natural sub-module, wb_csr_decode: combinational; takes the address and returns index, hit type (RW/RO/STAT/EN) and error flag.

Test Plan:
- Reset with RW_RESET word1=32'h0000_00fb: read 0x3000_0004 -> ack next cycle, dat=32'h0000_00fb; irq_o=0.
- Write 0x3000_0000 data 32'hAABBCCDD, sel=4'b0101, over 0 -> reg0=32'h00BB00DD; wr_pulse_o[0] high for exactly 1 cycle; read-back matches.
- Write to an RO word (0x3000_0010 with NUM_RW=4), and read 0x3000_0002 -> err_o 1 cycle, ack_o stays 0, no register changes.
- Pulse evt_i[3] for 1 cycle, then write EVT_ENABLE=32'h8 -> irq_o=1. Write EVT_STATUS=32'h8 -> status 0, irq_o=0.
- Hold evt_i[3]=1 while writing EVT_STATUS=32'h8 -> status bit remains 1 (set wins).
- Assert wb_rst_ni=0 the cycle after accepting a write -> no ack, reg returns to reset value, bus idle after release.
